// File: rtl/store_pkg.sv
// Shared definitions for the coordinate store and its sequencer:
// store geometry and the sequencer state encoding.
package store_pkg;

  localparam int NPTS = 6;   // points per frame and store depth
  localparam int AW   = 3;   // store address width
  localparam int DW   = 11;  // coordinate width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/point_seq_ctrl_if.sv
// Bus bundle around the sequencer: upstream point stream, store write/read
// ports and the downstream edge handshake. master = sequencer side,
// slave = surrounding system (point source, store, edge consumer).
interface point_seq_ctrl_if #(
  parameter int AW = 3,
  parameter int DW = 11
);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_x;
  logic [DW-1:0] in_y;

  logic          st_we;
  logic [AW-1:0] st_addr0;
  logic [AW-1:0] st_addr1;
  logic [DW-1:0] st_datax;
  logic [DW-1:0] st_datay;

  logic          edge_valid;
  logic          edge_ready;
  logic          edge_last;

  modport master (
    input  in_valid, in_x, in_y, edge_ready,
    output in_ready, st_we, st_addr0, st_addr1, st_datax, st_datay,
           edge_valid, edge_last
  );

  modport slave (
    output in_valid, in_x, in_y, edge_ready,
    input  in_ready, st_we, st_addr0, st_addr1, st_datax, st_datay,
           edge_valid, edge_last
  );

endinterface

// File: rtl/point_seq_ctrl_wrap_counter.sv
// Up-counter that wraps explicitly from LIMIT back to 0 (not modulo 2^W).
// clr has priority over en.
module wrap_counter #(
  parameter int W     = 3,
  parameter int LIMIT = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         at_max_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign at_max_o = (cnt_q == W'(LIMIT));
  assign cnt_o    = cnt_q;

  // next count: clear, hold, increment or wrap at LIMIT
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_max_o ? '0 : cnt_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/point_seq_ctrl.sv
// Frame sequencer for the x/y coordinate store: loads NPTS points from the
// upstream stream into the store, then walks every cyclic edge (i, i+1 mod
// NPTS) on the two read ports towards the edge-processing stage.
module point_seq_ctrl
  import store_pkg::*;
#(
  parameter int NPTS = store_pkg::NPTS,
  parameter int AW   = store_pkg::AW,
  parameter int DW   = store_pkg::DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  point_seq_ctrl_if.master bus,
  output logic             busy,
  output logic             done
);

  state_e        state_q;
  state_e        state_d;

  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] rd_cnt;
  logic          wr_at_max;
  logic          rd_at_max;
  logic          wr_en;
  logic          rd_en;
  logic          wr_clr;
  logic          rd_clr;
  logic          in_hs;
  logic          edge_hs;

  // Write pointer restarts from 0 whenever the sequencer idles, read pointer
  // while loading, so each phase always begins at address 0.
  assign wr_clr = (state_q == IDLE);
  assign rd_clr = (state_q == LOAD);

  wrap_counter #(.W(AW), .LIMIT(NPTS-1)) u_wr_cnt (
    .clk      (clk),
    .rst      (rst),
    .en_i     (wr_en),
    .clr_i    (wr_clr),
    .cnt_o    (wr_cnt),
    .at_max_o (wr_at_max)
  );

  wrap_counter #(.W(AW), .LIMIT(NPTS-1)) u_rd_cnt (
    .clk      (clk),
    .rst      (rst),
    .en_i     (rd_en),
    .clr_i    (rd_clr),
    .cnt_o    (rd_cnt),
    .at_max_o (rd_at_max)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state and all outputs; abort masks every handshake in its cycle
  always_comb begin
    state_d        = state_q;
    bus.in_ready   = 1'b0;
    bus.st_we      = 1'b0;
    bus.st_addr0   = '0;
    bus.st_addr1   = '0;
    bus.st_datax   = {DW{1'b0}};
    bus.st_datay   = {DW{1'b0}};
    bus.edge_valid = 1'b0;
    bus.edge_last  = 1'b0;
    wr_en          = 1'b0;
    rd_en          = 1'b0;
    in_hs          = 1'b0;
    edge_hs        = 1'b0;
    busy           = (state_q != IDLE);
    done           = (state_q == DONE);

    unique case (state_q)
      IDLE: begin
        if (start && !abort) state_d = LOAD;
      end

      LOAD: begin
        in_hs        = bus.in_valid && !abort;
        bus.in_ready = !abort;
        bus.st_we    = in_hs;
        bus.st_addr0 = wr_cnt;
        bus.st_datax = bus.in_x;
        bus.st_datay = bus.in_y;
        wr_en        = in_hs;
        if (abort)                   state_d = IDLE;
        else if (in_hs && wr_at_max) state_d = SCAN;
      end

      SCAN: begin
        edge_hs        = !abort && bus.edge_ready;
        bus.edge_valid = !abort;
        bus.st_addr0   = rd_cnt;
        bus.st_addr1   = rd_at_max ? '0 : rd_cnt + 1'b1;
        bus.edge_last  = rd_at_max;
        rd_en          = edge_hs;
        if (abort)                     state_d = IDLE;
        else if (edge_hs && rd_at_max) state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_point_seq_ctrl.sv
module tb_point_seq_ctrl;

  localparam int N  = 6;
  localparam int N4 = 4;
  localparam int DW = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic start, abort, busy, done;
  logic start4, abort4, busy4, done4;

  point_seq_ctrl_if #(.AW(3), .DW(DW)) bus6 ();
  point_seq_ctrl_if #(.AW(2), .DW(DW)) bus4 ();

  point_seq_ctrl #(.NPTS(N), .AW(3), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .bus(bus6), .busy(busy), .done(done)
  );

  point_seq_ctrl #(.NPTS(N4), .AW(2), .DW(DW)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .abort(abort4),
    .bus(bus4), .busy(busy4), .done(done4)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string nm, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Store model driven by the DUT's write port (the environment's memory)
  logic [DW-1:0] memx [8];
  logic [DW-1:0] memy [8];
  always @(posedge clk) begin
    if (bus6.st_we) begin
      memx[bus6.st_addr0] <= bus6.st_datax;
      memy[bus6.st_addr0] <= bus6.st_datay;
    end
  end

  // Behavioural model: phase (0 idle, 1 load, 2 scan, 3 done), points taken,
  // edges taken, and the points the frame should hold.
  int ph = 0, k = 0, e = 0;
  logic [DW-1:0] ex [N];
  logic [DW-1:0] ey [N];

  typedef struct { int a; int x; int y; } wr_t;
  typedef struct { int a0; int a1; int l; } ed_t;
  wr_t wr_q[$];
  ed_t ed_q[$];
  ed_t ed4_q[$];
  int done_cnt = 0, busy_cyc = 0, stall2_cyc = 0, d4_cnt = 0;
  int cyc = 0, last_edge_cyc = 0, done_cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("reset_outputs",
          {busy, done, bus6.in_ready, bus6.st_we, bus6.edge_valid, bus6.edge_last,
           bus6.st_addr0, bus6.st_addr1, bus6.st_datax, bus6.st_datay}, 0);
      ph = 0; k = 0; e = 0;
    end else begin
      chk("busy", busy, ph != 0);
      chk("done", done, ph == 3);
      chk("in_ready", bus6.in_ready, (ph == 1) && !abort);
      chk("st_we", bus6.st_we, (ph == 1) && !abort && bus6.in_valid);
      chk("edge_valid", bus6.edge_valid, (ph == 2) && !abort);
      if (ph == 1) begin
        chk("wr_addr", bus6.st_addr0, k);
        if (!abort && bus6.in_valid) begin
          chk("datax", bus6.st_datax, bus6.in_x);
          chk("datay", bus6.st_datay, bus6.in_y);
        end
      end
      if (ph == 2) begin
        chk("rd_addr0", bus6.st_addr0, e);
        chk("rd_addr1", bus6.st_addr1, (e + 1) % N);
        chk("edge_last", bus6.edge_last, e == N - 1);
        if (!abort && bus6.edge_ready) begin
          chk("edge_px0", {memx[bus6.st_addr0], memy[bus6.st_addr0]}, {ex[e], ey[e]});
          chk("edge_px1", {memx[bus6.st_addr1], memy[bus6.st_addr1]},
              {ex[(e + 1) % N], ey[(e + 1) % N]});
        end
        if (!abort && !bus6.edge_ready && e == 2 &&
            bus6.st_addr0 == 3'd2 && bus6.st_addr1 == 3'd3) stall2_cyc++;
      end
      if (ph == 0 || ph == 3) chk("idle_addr", {bus6.st_addr0, bus6.st_addr1}, 0);
      if (ph == 0) chk("idle_misc", {bus6.edge_last, bus6.st_datax, bus6.st_datay}, 0);

      // observations for the literal checks
      if (bus6.st_we) wr_q.push_back('{int'(bus6.st_addr0), int'(bus6.st_datax), int'(bus6.st_datay)});
      if (bus6.edge_valid && bus6.edge_ready) begin
        ed_q.push_back('{int'(bus6.st_addr0), int'(bus6.st_addr1), int'(bus6.edge_last)});
        last_edge_cyc = cyc;
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (busy) busy_cyc++;

      // advance the model across the coming clock edge
      if (abort) ph = 0;
      else begin
        case (ph)
          0: if (start) begin ph = 1; k = 0; end
          1: if (bus6.in_valid) begin
               ex[k] = bus6.in_x; ey[k] = bus6.in_y; k++;
               if (k == N) begin ph = 2; e = 0; end
             end
          2: if (bus6.edge_ready) begin e++; if (e == N) ph = 3; end
          default: ph = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus4.edge_valid && bus4.edge_ready)
      ed4_q.push_back('{int'(bus4.st_addr0), int'(bus4.st_addr1), int'(bus4.edge_last)});
    if (!rst && done4) d4_cnt++;
  end

  task automatic step(bit s, bit ab, bit v, int x, int y, bit er);
    @(posedge clk); #1;
    start = s; abort = ab;
    bus6.in_valid = v; bus6.in_x = DW'(x); bus6.in_y = DW'(y);
    bus6.edge_ready = er;
  endtask

  task automatic step4(bit s, bit v, int x, int y, bit er);
    @(posedge clk); #1;
    start4 = s;
    bus4.in_valid = v; bus4.in_x = DW'(x); bus4.in_y = DW'(y);
    bus4.edge_ready = er;
  endtask

  task automatic clear_obs();
    wr_q.delete(); ed_q.delete();
    done_cnt = 0; busy_cyc = 0; stall2_cyc = 0;
  endtask

  task automatic check_edges(string nm);
    int nxt [N];
    nxt = '{1, 2, 3, 4, 5, 0};
    chk({nm, "_n_edges"}, ed_q.size(), N);
    for (int i = 0; i < N && i < ed_q.size(); i++) begin
      chk({nm, "_e_a0"}, ed_q[i].a0, i);
      chk({nm, "_e_a1"}, ed_q[i].a1, nxt[i]);
      chk({nm, "_e_last"}, ed_q[i].l, i == N - 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    start = 0; abort = 0; start4 = 0; abort4 = 0;
    bus6.in_valid = 0; bus6.in_x = '0; bus6.in_y = '0; bus6.edge_ready = 0;
    bus4.in_valid = 0; bus4.in_x = '0; bus4.in_y = '0; bus4.edge_ready = 0;
    for (int i = 0; i < 8; i++) begin memx[i] = '0; memy[i] = '0; end
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (2) step(0, 0, 0, 0, 0, 1);

    // nominal frame
    clear_obs();
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < N; i++) step(0, 0, 1, i + 1, i + 2, 1);
    repeat (10) step(0, 0, 0, 0, 0, 1);
    chk("nom_n_writes", wr_q.size(), N);
    for (int i = 0; i < N && i < wr_q.size(); i++) begin
      chk("nom_w_addr", wr_q[i].a, i);
      chk("nom_w_xy", {wr_q[i].x, wr_q[i].y}, {i + 1, i + 2});
    end
    check_edges("nom");
    chk("nom_done_cnt", done_cnt, 1);
    chk("nom_done_after_last", done_cyc - last_edge_cyc, 1);
    chk("nom_busy_cycles", busy_cyc, 13);

    // backpressure: gaps on in_valid, 3-cycle stall on edge (2,3)
    clear_obs();
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < N; i++) begin
      step(0, 0, 1, 10 + i, 20 + i, 1);
      if (i < N - 1) step(0, 0, 0, 0, 0, 1);
    end
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0, 0, 1);
    chk("bp_n_writes", wr_q.size(), N);
    for (int i = 0; i < N && i < wr_q.size(); i++) chk("bp_w_addr", wr_q[i].a, i);
    chk("bp_stall_hold", stall2_cyc, 3);
    check_edges("bp");
    chk("bp_done_cnt", done_cnt, 1);

    // abort on the 4th point handshake
    clear_obs();
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 30 + i, 40 + i, 1);
    step(0, 1, 1, 99, 99, 1);
    #1;
    chk("ab_we", bus6.st_we, 0);
    chk("ab_ready", bus6.in_ready, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("ab_idle_next", busy, 0);
    repeat (4) step(0, 0, 0, 0, 0, 1);
    chk("ab_done_cnt", done_cnt, 0);
    chk("ab_n_writes", wr_q.size(), 3);
    chk("ab_entry3", {memx[3], memy[3]}, {11'd13, 11'd23});

    // async reset in the middle of SCAN at rd_cnt 3
    clear_obs();
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < N; i++) step(0, 0, 1, 50 + i, 60 + i, 1);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, 0, 0, 0, 1);
      #1;
      if (bus6.edge_valid && bus6.st_addr0 == 3'd3) found = 1;
    end
    chk("rst_reach_rd3", found, 1);
    rst = 1;
    #1;
    chk("rst_async_outs",
        {busy, done, bus6.in_ready, bus6.st_we, bus6.edge_valid, bus6.edge_last,
         bus6.st_addr0, bus6.st_addr1}, 0);
    @(posedge clk); #1 rst = 0;
    clear_obs();
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < N; i++) step(0, 0, 1, 70 + i, 80 + i, 1);
    repeat (10) step(0, 0, 0, 0, 0, 1);
    chk("rst_rerun_writes", wr_q.size(), N);
    for (int i = 0; i < N && i < wr_q.size(); i++) chk("rst_rerun_addr", wr_q[i].a, i);
    check_edges("rst");
    chk("rst_rerun_done", done_cnt, 1);

    // start held high through LOAD, SCAN and DONE; honoured in following IDLE
    clear_obs();
    step(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < N; i++) step(1, 0, 1, 90 + i, 100 + i, 1);
    repeat (N) step(1, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1);             // DONE cycle
    chk("st_done_cycle", done, 1);
    step(1, 0, 0, 0, 0, 1);             // IDLE cycle: start honoured
    chk("st_idle_cycle", busy, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("st_restart", busy, 1);
    check_edges("st");
    for (int i = 0; i < N; i++) step(0, 0, 1, i, i, 1);
    repeat (10) step(0, 0, 0, 0, 0, 1);
    chk("st_done_cnt", done_cnt, 2);
    chk("st_n_writes", wr_q.size(), 2 * N);

    // 4-point instance
    step4(1, 0, 0, 0, 1);
    for (int i = 0; i < N4; i++) step4(0, 1, i, i, 1);
    repeat (8) step4(0, 0, 0, 0, 1);
    chk("n4_n_edges", ed4_q.size(), 4);
    if (ed4_q.size() == 4) begin
      chk("n4_e0", {ed4_q[0].a0, ed4_q[0].a1, ed4_q[0].l}, {32'd0, 32'd1, 32'd0});
      chk("n4_e1", {ed4_q[1].a0, ed4_q[1].a1, ed4_q[1].l}, {32'd1, 32'd2, 32'd0});
      chk("n4_e2", {ed4_q[2].a0, ed4_q[2].a1, ed4_q[2].l}, {32'd2, 32'd3, 32'd0});
      chk("n4_e3", {ed4_q[3].a0, ed4_q[3].a1, ed4_q[3].l}, {32'd3, 32'd0, 32'd1});
    end
    chk("n4_done", d4_cnt, 1);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 49) == 0,
           $urandom_range(0, 3) != 0, int'($urandom_range(0, 2047)),
           int'($urandom_range(0, 2047)), $urandom_range(0, 3) != 0);
    end
    repeat (3) step(0, 1, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
